// File: rtl/uart_defs.sv
// Shared UART definitions: byte width, status-register bit positions and
// the default receive FIFO depth.
package uart_defs;

  localparam int BYTE_W = 8;

  // Status register bit indices
  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_RX_AVAIL   = 1;
  localparam int STAT_RX_OVERRUN = 2;
  localparam int STAT_RX_FULL    = 3;

  localparam int RX_FIFO_DEPTH_DEFAULT = 16;
  localparam int RX_FIFO_ADDR_W_DEFAULT = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO downstream of the UART receiver, first-word-fall-
// through read port, count/empty/full status and a sticky overrun flag.
// Optional macro UART_RX_FIFO_HWM_EN adds the hwm (high-water-mark) output.
//
// Strobe semantics: wr_valid and rd_pop are single-cycle strobes with no
// back-pressure. A push is accepted when wr_valid=1 and the FIFO is not full
// or a pop is accepted in the same cycle; otherwise the byte is dropped and
// overrun is set. A pop is accepted when rd_pop=1 and the FIFO is not empty;
// a pop on an empty FIFO is ignored. rd_data shows the head entry while
// empty=0 and reads 0 when empty.
module uart_rx_fifo
  import uart_defs::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = RX_FIFO_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              rd_pop,
  output logic [BYTE_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
`ifdef UART_RX_FIFO_HWM_EN
  output logic [ADDR_W:0]   hwm,
`endif
  input  logic              overrun_clr
);

  localparam logic [ADDR_W:0]   L_DEPTH   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   L_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] L_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [ADDR_W:0]   w_count_nxt;

  // Accept/drop decisions; count is the single source of occupancy truth
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == L_DEPTH);
    w_pop   = rd_pop & ~w_empty;
    w_push  = wr_valid & (~w_full | w_pop);
    w_drop  = wr_valid & w_full & ~w_pop;
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + L_CNT_ONE;
    else if (w_pop && !w_push) w_count_nxt = r_count - L_CNT_ONE;
  end

  // Pointer, count and sticky overrun registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      r_count <= w_count_nxt;
      // A new overrun in the same cycle as a clear must not be lost
      if (w_drop)           r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
    end
  end

  // Storage array, intentionally not reset so it can map to block RAM
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

`ifdef UART_RX_FIFO_HWM_EN
  logic [ADDR_W:0] r_hwm;

  // High-water mark: peak occupancy since reset or the last overrun_clr
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hwm <= '0;
    end else if (overrun_clr) begin
      r_hwm <= r_count;
    end else if (w_count_nxt > r_hwm) begin
      r_hwm <= w_count_nxt;
    end
  end

  assign hwm = r_hwm;
`endif

  // First-word-fall-through read, forced to 0 when nothing is stored
  always_comb begin
    rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
  end

  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

  logic       clk;
  logic       nrst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       rd_pop;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       overrun_clr;
`ifdef UART_RX_FIFO_HWM_EN
  logic [4:0] hwm;
`endif

  int n_vec;
  int n_err;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .rd_pop      (rd_pop),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
`ifdef UART_RX_FIFO_HWM_EN
    .hwm         (hwm),
`endif
    .overrun_clr (overrun_clr)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the edge, outputs sampled there
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
  endtask

  task automatic clear_ovr();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nrst = 1'b0;
    wr_data = 8'h00;
    wr_valid = 1'b0;
    rd_pop = 1'b0;
    overrun_clr = 1'b0;
    #1;
    check("rst_empty", 16'(empty), 16'd1);
    check("rst_full", 16'(full), 16'd0);
    check("rst_count", 16'(count), 16'd0);
    check("rst_rd_data", 16'(rd_data), 16'h00);
    check("rst_overrun", 16'(overrun), 16'd0);
`ifdef UART_RX_FIFO_HWM_EN
    check("rst_hwm", 16'(hwm), 16'd0);
`endif
    tick();
    nrst = 1'b1;
    tick();

    // Ordering
    push(8'h41);
    push(8'h42);
    push(8'h43);
    check("ord_head", 16'(rd_data), 16'h41);
    check("ord_count", 16'(count), 16'd3);
    pop();
    check("ord_pop1", 16'(rd_data), 16'h42);
    pop();
    check("ord_pop2", 16'(rd_data), 16'h43);
    pop();
    check("ord_empty", 16'(empty), 16'd1);
    check("ord_rd_zero", 16'(rd_data), 16'h00);

    // Fill to full (pointers wrap since they start at 3), then overrun
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", 16'(full), 16'd1);
    check("fill_count", 16'(count), 16'd16);
`ifdef UART_RX_FIFO_HWM_EN
    check("fill_hwm", 16'(hwm), 16'd16);
`endif
    push(8'hFF);
    check("ovr_flag", 16'(overrun), 16'd1);
    check("ovr_count", 16'(count), 16'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 16'(rd_data), 16'(i));
      pop();
    end
    check("drain_empty", 16'(empty), 16'd1);
    check("drain_count", 16'(count), 16'd0);

    // Lone clear drops overrun
    clear_ovr();
    check("clr_lone", 16'(overrun), 16'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(8'(i));
    wr_data  = 8'h55;
    wr_valid = 1'b1;
    rd_pop   = 1'b1;
    tick();
    wr_valid = 1'b0;
    rd_pop   = 1'b0;
    check("fpp_count", 16'(count), 16'd16);
    check("fpp_overrun", 16'(overrun), 16'd0);
    check("fpp_head", 16'(rd_data), 16'h01);
    for (int i = 1; i < 16; i++) pop();
    check("fpp_last", 16'(rd_data), 16'h55);
    check("fpp_last_cnt", 16'(count), 16'd1);
    pop();
    check("fpp_empty", 16'(empty), 16'd1);

    // Empty with simultaneous push and pop
    wr_data  = 8'h7E;
    wr_valid = 1'b1;
    rd_pop   = 1'b1;
    tick();
    wr_valid = 1'b0;
    rd_pop   = 1'b0;
    check("epp_count", 16'(count), 16'd1);
    check("epp_data", 16'(rd_data), 16'h7E);
    pop();
    check("epp_drained", 16'(empty), 16'd1);
    pop();
    check("pop_empty_cnt", 16'(count), 16'd0);
    check("pop_empty_flag", 16'(empty), 16'd1);
    push(8'h11);
    check("pop_empty_next", 16'(rd_data), 16'h11);
    check("pop_empty_next_cnt", 16'(count), 16'd1);
    pop();

    // Clear coinciding with an overrun: set wins
    for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
    wr_data     = 8'hEE;
    wr_valid    = 1'b1;
    overrun_clr = 1'b1;
    tick();
    wr_valid    = 1'b0;
    overrun_clr = 1'b0;
    check("clr_set_wins", 16'(overrun), 16'd1);
    check("clr_set_cnt", 16'(count), 16'd16);
    clear_ovr();
    check("clr_after", 16'(overrun), 16'd0);
    pop();
    pop();
    pop();
    check("clr_head", 16'(rd_data), 16'hA3);
`ifdef UART_RX_FIFO_HWM_EN
    check("hwm_keep", 16'(hwm), 16'd16);
    clear_ovr();
    check("hwm_clr", 16'(hwm), 16'd13);
`endif

    // Asynchronous reset mid-traffic
    push(8'h21);
    push(8'h22);
    push(8'h23);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_empty", 16'(empty), 16'd1);
    check("arst_count", 16'(count), 16'd0);
    check("arst_rd_data", 16'(rd_data), 16'h00);
    check("arst_overrun", 16'(overrun), 16'd0);
    tick();
    nrst = 1'b1;
    tick();
    tick();
    check("arst_hold_empty", 16'(empty), 16'd1);
    check("arst_hold_count", 16'(count), 16'd0);
    push(8'h99);
    check("arst_post_push", 16'(rd_data), 16'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
